// File: rtl/tdm_demux8_1_pkg.sv
// Shared constants and types for the 8:1 TDM receive path.
package tdm_demux8_1_pkg;

  localparam int unsigned DATA_W  = 1;
  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned FRAME_W = N_SLOTS * DATA_W;

  localparam logic [SEL_W-1:0] SLOT_FIRST = SEL_W'(0);
  localparam logic [SEL_W-1:0] SLOT_LAST  = SEL_W'(N_SLOTS - 1);

  typedef logic [FRAME_W-1:0] frame_t;

  // Slots 0..N_SLOTS-2 are held until the last sample of the frame arrives
  typedef logic [N_SLOTS-2:0][DATA_W-1:0] shadow_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/tdm_demux8_1_if.sv
// Serial-in / frame-out bus of the TDM receiver.
interface tdm_demux8_1_if;
  import tdm_demux8_1_pkg::*;

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              frame_sync;
  frame_t            dout;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  slot_idx;
  logic              locked;
  logic              sync_err;
  logic              overrun;

  // Source of the serial stream and consumer of frames
  modport master (
    output din, din_valid, frame_sync, out_ready,
    input  dout, out_valid, slot_idx, locked, sync_err, overrun
  );

  // Receiver side
  modport slave (
    input  din, din_valid, frame_sync, out_ready,
    output dout, out_valid, slot_idx, locked, sync_err, overrun
  );

endinterface

// File: rtl/tdm_demux8_1_demux1_8.sv
// 1:8 demultiplexer of an enable onto a one-hot select, built as a 1:2 -> 1:4 -> 1:8 tree.
module tdm_demux8_1_demux1_8
  import tdm_demux8_1_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [N_SLOTS-1:0] onehot_c
);

  logic [1:0] st2_c;
  logic [3:0] st4_c;

  // Steer en by sel[2], then sel[1], then sel[0]; output index equals sel
  always_comb begin
    st2_c    = '0;
    st4_c    = '0;
    onehot_c = '0;
    st2_c[0] = en & ~sel[2];
    st2_c[1] = en &  sel[2];
    for (int i = 0; i < 2; i++) begin
      st4_c[2*i]     = st2_c[i] & ~sel[1];
      st4_c[2*i + 1] = st2_c[i] &  sel[1];
    end
    for (int j = 0; j < 4; j++) begin
      onehot_c[2*j]     = st4_c[j] & ~sel[0];
      onehot_c[2*j + 1] = st4_c[j] &  sel[0];
    end
  end

endmodule

// File: rtl/tdm_demux8_1.sv
// Receive end of the 8:1 TDM link: frame lock, slot steering, frame output with handshake.
module tdm_demux8_1
  import tdm_demux8_1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux8_1_if.slave     bus
);

  lock_state_t        state_q, state_n;
  logic [SEL_W-1:0]   slot_q, slot_n;
  shadow_t            shadow_q, shadow_n;
  frame_t             dout_q, dout_n;
  logic               out_valid_q, out_valid_n;
  logic               sync_err_q, sync_err_n;
  logic               overrun_q, overrun_n;

  logic               wr_en_c;
  logic [SEL_W-1:0]   wr_sel_c;
  logic               clr_c;
  logic [N_SLOTS-1:0] onehot_c;
  logic               complete_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNLOCKED;
      slot_q      <= SLOT_FIRST;
      shadow_q    <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      slot_q      <= slot_n;
      shadow_q    <= shadow_n;
      dout_q      <= dout_n;
      out_valid_q <= out_valid_n;
      sync_err_q  <= sync_err_n;
      overrun_q   <= overrun_n;
    end
  end

  // Lock FSM: decides whether the sample is written, to which slot, and framing errors
  always_comb begin
    state_n    = state_q;
    sync_err_n = 1'b0;
    wr_en_c    = 1'b0;
    wr_sel_c   = slot_q;
    clr_c      = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (bus.frame_sync) begin
            state_n  = ST_LOCKED;
            wr_en_c  = 1'b1;
            wr_sel_c = SLOT_FIRST;
            clr_c    = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (bus.frame_sync && (slot_q != SLOT_FIRST)) begin
            // Early sync: drop the partial frame and restart at slot 0
            sync_err_n = 1'b1;
            wr_en_c    = 1'b1;
            wr_sel_c   = SLOT_FIRST;
            clr_c      = 1'b1;
          end else if (!bus.frame_sync && (slot_q == SLOT_FIRST)) begin
            // Missing sync: lose lock and drop the sample
            sync_err_n = 1'b1;
            state_n    = ST_UNLOCKED;
          end else begin
            wr_en_c = 1'b1;
          end
        end
        default: state_n = ST_UNLOCKED;
      endcase
    end
  end

  tdm_demux8_1_demux1_8 u_demux1_8 (
    .sel      (wr_sel_c),
    .en       (wr_en_c),
    .onehot_c (onehot_c)
  );

  assign complete_c = onehot_c[SLOT_LAST];

  // Datapath: shadow writes, slot advance, frame completion and output handshake
  always_comb begin
    slot_n      = slot_q;
    shadow_n    = clr_c ? '0 : shadow_q;
    dout_n      = dout_q;
    out_valid_n = out_valid_q;
    overrun_n   = overrun_q;
    for (int k = 0; k < int'(N_SLOTS - 1); k++) begin
      if (onehot_c[k]) begin
        shadow_n[k] = bus.din;
      end
    end
    if (wr_en_c) begin
      slot_n = wr_sel_c + SEL_W'(1);
    end
    if (complete_c) begin
      dout_n      = {bus.din, shadow_q};
      shadow_n    = '0;
      out_valid_n = 1'b1;
      if (out_valid_q && !bus.out_ready) begin
        overrun_n = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_n = 1'b0;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot_idx  = slot_q;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.sync_err  = sync_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux8_1.sv
// Directed bench for the TDM receiver.
module tb_tdm_demux8_1;
  import tdm_demux8_1_pkg::*;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  tdm_demux8_1_if bus ();

  tdm_demux8_1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, then sample 1 time unit after the edge
  task automatic send(input logic d, input logic fs, input logic v);
    bus.din        = d;
    bus.frame_sync = fs;
    bus.din_valid  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send(1'b0, 1'b0, 1'b0);
  endtask

  // Whole frame, slot k carries bits[k], sync on slot 0
  task automatic send_frame(input logic [7:0] bits);
    for (int k = 0; k < 8; k++) send(bits[k], k == 0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    idle();
    total_cnt++;
    if (bus.dout !== 8'h00 || bus.out_valid !== 1'b0 || bus.slot_idx !== 3'd0 ||
        bus.locked !== 1'b0 || bus.sync_err !== 1'b0 || bus.overrun !== 1'b0)
      $display("FAIL reset_outputs: got dout=%h ov=%b slot=%0d lk=%b se=%b orun=%b want all 0",
               bus.dout, bus.out_valid, bus.slot_idx, bus.locked, bus.sync_err, bus.overrun);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [7:0] bits;
    bits = 8'b1001_0110;
    bus.out_ready = 1'b1;
    send(bits[0], 1'b1, 1'b1);
    total_cnt++;
    if (bus.locked !== 1'b1 || bus.slot_idx !== 3'd1)
      $display("FAIL basic_lock: got lk=%b slot=%0d want lk=1 slot=1", bus.locked, bus.slot_idx);
    else pass_cnt++;
    for (int k = 1; k < 8; k++) send(bits[k], 1'b0, 1'b1);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 8'h96)
      $display("FAIL basic_frame: got ov=%b dout=%h want ov=1 dout=96", bus.out_valid, bus.dout);
    else pass_cnt++;
    total_cnt++;
    if (bus.locked !== 1'b1 || bus.slot_idx !== 3'd0)
      $display("FAIL basic_wrap: got lk=%b slot=%0d want lk=1 slot=0", bus.locked, bus.slot_idx);
    else pass_cnt++;
    idle();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.dout !== 8'h96)
      $display("FAIL basic_pulse: got ov=%b dout=%h want ov=0 dout=96", bus.out_valid, bus.dout);
    else pass_cnt++;
  endtask

  task automatic test_pre_sync();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (bus.locked !== 1'b0 || bus.slot_idx !== 3'd0 || bus.out_valid !== 1'b0)
      $display("FAIL pre_sync: got lk=%b slot=%0d ov=%b want 0 0 0",
               bus.locked, bus.slot_idx, bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [7:0] bits;
    bits = 8'b1001_0110;
    for (int k = 0; k < 7; k++) begin
      send(bits[k], k == 0, 1'b1);
      idle();
      if (k % 2 == 1) idle();
    end
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.slot_idx !== 3'd7)
      $display("FAIL gaps_partial: got ov=%b slot=%0d want ov=0 slot=7", bus.out_valid, bus.slot_idx);
    else pass_cnt++;
    send(bits[7], 1'b0, 1'b1);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 8'h96)
      $display("FAIL gaps_frame: got ov=%b dout=%h want ov=1 dout=96", bus.out_valid, bus.dout);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_resync();
    logic [7:0] bits;
    bits = 8'h55;
    send(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 4; k++) send(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (bus.slot_idx !== 3'd4)
      $display("FAIL resync_pre: got slot=%0d want 4", bus.slot_idx);
    else pass_cnt++;
    send(bits[0], 1'b1, 1'b1);
    total_cnt++;
    if (bus.sync_err !== 1'b1 || bus.slot_idx !== 3'd1 || bus.locked !== 1'b1)
      $display("FAIL resync_err: got se=%b slot=%0d lk=%b want se=1 slot=1 lk=1",
               bus.sync_err, bus.slot_idx, bus.locked);
    else pass_cnt++;
    idle();
    total_cnt++;
    if (bus.sync_err !== 1'b0)
      $display("FAIL resync_pulse: got se=%b want 0", bus.sync_err);
    else pass_cnt++;
    for (int k = 1; k < 8; k++) send(bits[k], 1'b0, 1'b1);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 8'h55)
      $display("FAIL resync_frame: got ov=%b dout=%h want ov=1 dout=55", bus.out_valid, bus.dout);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_missing_sync();
    send(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.slot_idx !== 3'd0 ||
        bus.out_valid !== 1'b0)
      $display("FAIL missing_sync: got se=%b lk=%b slot=%0d ov=%b want 1 0 0 0",
               bus.sync_err, bus.locked, bus.slot_idx, bus.out_valid);
    else pass_cnt++;
    idle();
    total_cnt++;
    if (bus.sync_err !== 1'b0)
      $display("FAIL missing_pulse: got se=%b want 0", bus.sync_err);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bus.out_ready = 1'b0;
    send_frame(8'h0F);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 8'h0F || bus.overrun !== 1'b0)
      $display("FAIL b2b_first: got ov=%b dout=%h orun=%b want 1 0f 0",
               bus.out_valid, bus.dout, bus.overrun);
    else pass_cnt++;
    bits = 8'hA5;
    for (int k = 0; k < 7; k++) send(bits[k], k == 0, 1'b1);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 8'h0F)
      $display("FAIL b2b_hold: got ov=%b dout=%h want ov=1 dout=0f", bus.out_valid, bus.dout);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    send(bits[7], 1'b0, 1'b1);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 8'hA5 || bus.overrun !== 1'b0)
      $display("FAIL b2b_same_edge: got ov=%b dout=%h orun=%b want 1 a5 0",
               bus.out_valid, bus.dout, bus.overrun);
    else pass_cnt++;
    bus.out_ready = 1'b0;
    send_frame(8'h3C);
    total_cnt++;
    if (bus.overrun !== 1'b1 || bus.dout !== 8'h3C || bus.out_valid !== 1'b1)
      $display("FAIL overrun_set: got orun=%b dout=%h ov=%b want 1 3c 1",
               bus.overrun, bus.dout, bus.out_valid);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    idle();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1 || bus.dout !== 8'h3C)
      $display("FAIL overrun_drain: got ov=%b orun=%b dout=%h want 0 1 3c",
               bus.out_valid, bus.overrun, bus.dout);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    send(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) send(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (bus.slot_idx !== 3'd5)
      $display("FAIL arst_pre: got slot=%0d want 5", bus.slot_idx);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.dout !== 8'h00 || bus.out_valid !== 1'b0 || bus.slot_idx !== 3'd0 ||
        bus.locked !== 1'b0 || bus.sync_err !== 1'b0 || bus.overrun !== 1'b0)
      $display("FAIL arst_outputs: got dout=%h ov=%b slot=%0d lk=%b se=%b orun=%b want all 0",
               bus.dout, bus.out_valid, bus.slot_idx, bus.locked, bus.sync_err, bus.overrun);
    else pass_cnt++;
    idle();
    rst_n = 1'b1;
    send(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (bus.locked !== 1'b0 || bus.slot_idx !== 3'd0)
      $display("FAIL arst_relock: got lk=%b slot=%0d want lk=0 slot=0", bus.locked, bus.slot_idx);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_basic_frame();
    test_pre_sync();
    test_gaps();
    test_resync();
    test_missing_sync();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
